// File: rtl/tdm_demux_4ch.sv
// Receive end of a 4-channel TDM link: serial MSB-first bits are collected into
// four W-bit channel slots per frame, with frame-sync hunting and resync on error.
module tdm_demux_4ch #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           din_valid,
    input  logic           fsync,
    output logic [4*W-1:0] ch_data,
    output logic [3:0]     ch_valid,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);

    localparam int unsigned IW = $clog2(4 * W);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  w_idx_nxt;
    // Only W-1 history bits are stored; the incoming din completes each word.
    logic [W-2:0]   r_shift;
    logic [W-2:0]   w_shift_nxt;
    logic [W-1:0]   w_word;
    logic [4*W-1:0] r_data;
    logic [4*W-1:0] w_data_nxt;
    logic [3:0]     r_valid;
    logic [3:0]     w_valid_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_err;
    logic           w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_word      = {r_shift, din};

        if (din_valid) begin
            if (fsync) begin
                // In RECV the index is never 0, so any sync there is mid-frame.
                w_err_nxt   = (r_state == RECV);
                w_shift_nxt = (W-1)'(din);
                w_idx_nxt   = IW'(1);
                w_state_nxt = RECV;
            end else if (r_state == RECV) begin
                w_shift_nxt = w_word[W-2:0];
                w_idx_nxt   = r_idx + IW'(1);
                for (int unsigned k = 0; k < 4; k++) begin
                    if (r_idx == IW'(k * W + W - 1)) begin
                        w_data_nxt[k*W +: W] = w_word;
                        w_valid_nxt[k]       = 1'b1;
                    end
                end
                if (r_idx == IW'(4 * W - 1)) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign ch_data    = r_data;
    assign ch_valid   = r_valid;
    assign frame_done = r_done;
    assign sync_err   = r_err;
    assign locked     = (r_state == RECV);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed frame table, corner-case
// sequences and randomized traffic against a queue-based frame model.
module tb_tdm_demux_4ch;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           din = 1'b0;
    logic           din_valid = 1'b0;
    logic           fsync = 1'b0;
    logic [4*W-1:0] ch_data;
    logic [3:0]     ch_valid;
    logic           frame_done;
    logic           sync_err;
    logic           locked;

    tdm_demux_4ch #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .fsync      (fsync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_valid = 0;
    int cnt_fd = 0;
    int cnt_err = 0;

    // Reference model: bits of the frame in progress (empty while hunting).
    bit             mq[$];
    logic [4*W-1:0] m_data;
    logic [3:0]     m_valid;
    logic           m_fd;
    logic           m_err;

    typedef struct {
        bit         d;
        bit         v;
        bit         fs;
        logic [3:0] ev;
        bit         efd;
        bit         eerr;
        bit         elock;
    } vec_t;

    vec_t tbl[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_data  = '0;
        m_valid = '0;
        m_fd    = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_beat(input bit d, input bit v, input bit fs);
        int n;
        logic [W-1:0] word;
        m_valid = '0;
        m_fd    = 1'b0;
        m_err   = 1'b0;
        if (!v) return;
        if (fs) begin
            if (mq.size() != 0) m_err = 1'b1;
            mq.delete();
            mq.push_back(d);
        end else if (mq.size() != 0) begin
            mq.push_back(d);
            n = mq.size();
            if (n % W == 0) begin
                word = '0;
                for (int j = n - W; j < n; j++) word = {word[W-2:0], mq[j]};
                m_data[(n/W-1)*W +: W] = word;
                m_valid[n/W-1] = 1'b1;
                if (n == 4 * W) begin
                    m_fd = 1'b1;
                    mq.delete();
                end
            end
        end
    endfunction

    function automatic bit fbit(input logic [4*W-1:0] f, input int i);
        return f[(i / W) * W + (W - 1 - i % W)];
    endfunction

    task automatic step(input bit d, input bit v, input bit fs);
        din       = d;
        din_valid = v;
        fsync     = fs;
        @(posedge clk);
        #1;
        model_beat(d, v, fs);
        chk("ch_data", ch_data, m_data);
        chk("ch_valid", ch_valid, m_valid);
        chk("frame_done", frame_done, m_fd);
        chk("sync_err", sync_err, m_err);
        chk("locked", locked, mq.size() != 0);
        cnt_valid += $countones(ch_valid);
        cnt_fd    += int'(frame_done);
        cnt_err   += int'(sync_err);
    endtask

    task automatic clear_counts();
        cnt_valid = 0;
        cnt_fd    = 0;
        cnt_err   = 0;
    endtask

    // Called at posedge+1; asserts reset between edges and checks the async clear.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ch_data", ch_data, '0);
        chk("rst_ch_valid", ch_valid, '0);
        chk("rst_frame_done", frame_done, '0);
        chk("rst_sync_err", sync_err, '0);
        chk("rst_locked", locked, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [4*W-1:0] f, input int gap_every, input int gap_len);
        for (int i = 0; i < 4 * W; i++) begin
            step(fbit(f, i), 1'b1, i == 0);
            if (gap_every > 0 && (i + 1) % gap_every == 0 && i != 4 * W - 1) begin
                for (int g = 0; g < gap_len; g++) step(1'($urandom), 1'b0, 1'($urandom));
            end
        end
    endtask

    localparam logic [4*W-1:0] F1 = 32'h01FF3CA5;
    localparam logic [4*W-1:0] F2 = 32'hC37F8000;

    initial begin
        logic [4*W-1:0] f1;
        logic [4*W-1:0] f2;
        f1 = F1;
        f2 = F2;
        model_reset();

        for (int i = 0; i < 4 * W; i++) begin
            tbl[i].d     = fbit(f1, i);
            tbl[i].v     = 1'b1;
            tbl[i].fs    = (i == 0);
            tbl[i].ev    = (i % W == W - 1) ? (4'(1) << (i / W)) : 4'b0000;
            tbl[i].efd   = (i == 4 * W - 1);
            tbl[i].eerr  = 1'b0;
            tbl[i].elock = (i != 4 * W - 1);
        end

        @(posedge clk);
        #1;
        do_reset();

        // Continuous frame from the table
        for (int i = 0; i < 4 * W; i++) begin
            step(tbl[i].d, tbl[i].v, tbl[i].fs);
            chk("tbl_ch_valid", ch_valid, tbl[i].ev);
            chk("tbl_frame_done", frame_done, tbl[i].efd);
            chk("tbl_sync_err", sync_err, tbl[i].eerr);
            chk("tbl_locked", locked, tbl[i].elock);
        end
        chk("tbl_final_data", ch_data, f1);
        step(1'b1, 1'b1, 1'b0);
        chk("idle_after_frame_locked", locked, 1'b0);

        // Frame with 3-cycle gaps after every 5th bit
        do_reset();
        clear_counts();
        send_frame(f1, 5, 3);
        chk("gap_data", ch_data, f1);
        chk("gap_valid_count", cnt_valid, 4);
        chk("gap_fd_count", cnt_fd, 1);

        // Sync error at beat 11
        do_reset();
        clear_counts();
        for (int i = 0; i < 10; i++) step(fbit(f1, i), 1'b1, i == 0);
        step(fbit(f2, 0), 1'b1, 1'b1);
        chk("serr_slot0", ch_data[W-1:0], 8'hA5);
        chk("serr_count", cnt_err, 1);
        chk("serr_valid_count", cnt_valid, 1);
        for (int i = 1; i < 4 * W; i++) step(fbit(f2, i), 1'b1, 1'b0);
        chk("serr_new_frame", ch_data, f2);
        chk("serr_fd_count", cnt_fd, 1);
        chk("serr_total_err", cnt_err, 1);

        // 20 beats without fsync while hunting, then a frame
        do_reset();
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'($urandom), 1'b1, 1'b0);
        chk("hunt_activity", cnt_valid + cnt_fd + cnt_err, 0);
        chk("hunt_data", ch_data, '0);
        send_frame(f1, 0, 0);
        chk("hunt_frame", ch_data, f1);

        // Reset at beat 20, then bits without fsync are ignored
        do_reset();
        for (int i = 0; i < 20; i++) step(fbit(f1, i), 1'b1, i == 0);
        chk("pre_reset_partial", ch_data[2*W-1:0], 16'h3CA5);
        do_reset();
        clear_counts();
        for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, 1'b0);
        chk("post_reset_locked", locked, 1'b0);
        chk("post_reset_activity", cnt_valid, 0);
        send_frame(f2, 0, 0);
        chk("post_reset_frame", ch_data, f2);

        // Back-to-back frames
        do_reset();
        clear_counts();
        send_frame(f1, 0, 0);
        send_frame(f2, 0, 0);
        chk("b2b_valid_count", cnt_valid, 8);
        chk("b2b_fd_count", cnt_fd, 2);
        chk("b2b_data", ch_data, f2);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter: W, default 8, bits per channel slot (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  serial TDM data bit, MSB of each channel first.
REQ-005 Port: din_valid  input  1  qualifies din and fsync; when low, the input is ignored for that cycle.
REQ-006 Port: fsync  input  1  marks din as bit 0 (channel 0 MSB) of a frame; meaningful only with din_valid=1.
REQ-007 Port: ch_data  output  4*W  channel registers; slot k occupies bits [k*W+W-1 : k*W].
REQ-008 Port: ch_valid  output  4  one-cycle pulse per channel when its slot in ch_data is updated.
REQ-009 Port: frame_done  output  1  one-cycle pulse when channel 3 of a frame completes.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a frame sync seen mid-frame.
REQ-011 Port: locked  output  1  high while the state machine is in RECV.

Function
REQ-012 The block SHALL be the receive end of a 4-channel TDM link: frame = 4*W valid bits, channel 0 first, MSB first within a channel.
REQ-013 State machine SHALL have two states: IDLE (hunting for sync) and RECV (collecting a frame).
REQ-014 The bit index within a frame SHALL be held in a counter 0..4*W-1; channel = index / W, bit-in-channel = index mod W.
REQ-015 A "beat" SHALL be a cycle with din_valid=1; counter, shift register and state SHALL change only on beats (except reset).
REQ-016 IDLE, beat with fsync=1: shift din in as bit 0, set index to 1, go to RECV.
REQ-017 IDLE, beat with fsync=0: the bit SHALL be discarded, with no output change.
REQ-018 RECV, beat with fsync=0: shift din into the channel shift register and increment the index.
REQ-019 When a beat carries bit-in-channel W-1 of channel k, the full W-bit word SHALL be written to slot k on that same edge, and ch_valid[k] SHALL be high for exactly the following cycle.
REQ-020 On the beat carrying frame index 4*W-1:
  - ch_valid[3] and frame_done SHALL both pulse;
  - index SHALL wrap to 0;
  - the state SHALL return to IDLE.
REQ-021 Back-to-back frames SHALL be supported: an fsync beat in the cycle immediately after frame completion starts a new frame with no lost bit.
REQ-022 RECV, beat with fsync=1 (always mid-frame, since index≠0 in RECV):
  - sync_err SHALL pulse for one cycle;
  - the partial channel SHALL be discarded;
  - this bit becomes bit 0 of a new frame (index=1);
  - the state stays in RECV.
REQ-023 Slots already completed before a sync error SHALL retain their values; no ch_valid SHALL pulse for the discarded partial channel.
REQ-024 din_valid=0 in any state SHALL freeze the index, the shift register and the state; fsync SHALL be ignored in that cycle.
REQ-025 All outputs SHALL be registered; ch_data slots not being written SHALL hold their values.
REQ-026 locked SHALL be high exactly while the state is RECV.

Reset
REQ-027 rst_n low SHALL immediately force all of the following, independent of clk:
  - state=IDLE, index=0, shift register=0;
  - ch_data=0, ch_valid=0, frame_done=0, sync_err=0, locked=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh fsync beat.
REQ-029 The first rising clk edge at or after rst_n deassertion SHALL be treated as an ordinary cycle.

Verification (W=8)
REQ-030 Continuous frame, fsync on bit 0, channels 0xA5,0x3C,0xFF,0x01 -> ch_valid[0..3] pulse at beats 8/16/24/32; ch_data=0x01FF3CA5; frame_done coincides with ch_valid[3]; locked low afterwards.
REQ-031 Same frame, din_valid low for 3 cycles after every 5th bit -> identical ch_data and pulse sequence, delayed only by the gaps.
REQ-032 Second fsync at beat 11 of a frame (0xA5 already received) -> sync_err pulses once; slot 0 stays 0xA5 with no ch_valid[1]; the next 32 beats decode as a new full frame.
REQ-033 20 beats with fsync=0 in IDLE, then a valid frame -> no output activity during the 20 beats; the frame decodes correctly.
REQ-034 rst_n pulsed low at beat 20 -> all outputs 0 asynchronously and locked=0; bits without fsync are then ignored until the next fsync beat.
REQ-035 Two frames back-to-back, second with channels 0x00,0x80,0x7F,0xC3 -> 8 ch_valid pulses and 2 frame_done pulses; final ch_data=0xC37F8000.
